// File: rtl/ex_mem_pkg.sv
// Shared widths, memory-op encodings and small op-classification helpers
// for the execute/memory pipeline boundary.
package ex_mem_pkg;

    localparam int REG_BUS       = 32;
    localparam int REG_ADDR_BUS  = 5;
    localparam int CSR_ADDR_BUS  = 12;
    localparam int CSR_BUS       = 32;
    localparam int DBUS_BE_BUS   = 4;
    localparam logic RST_ENABLE  = 1'b0;

    localparam logic [3:0] MEM_OP_NONE = 4'h0;
    localparam logic [3:0] MEM_OP_LB   = 4'h1;
    localparam logic [3:0] MEM_OP_LH   = 4'h2;
    localparam logic [3:0] MEM_OP_LW   = 4'h3;
    localparam logic [3:0] MEM_OP_LBU  = 4'h4;
    localparam logic [3:0] MEM_OP_LHU  = 4'h5;
    localparam logic [3:0] MEM_OP_SB   = 4'h6;
    localparam logic [3:0] MEM_OP_SH   = 4'h7;
    localparam logic [3:0] MEM_OP_SW   = 4'h8;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

    // Unknown encodings fall through as non-memory ops.
    function automatic logic op_is_mem(input logic [3:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Data-bus request/grant/rvalid interface; master issues requests, slave answers.
interface ex_mem_if;
    import ex_mem_pkg::*;

    logic                    req;
    logic                    we;
    logic [REG_BUS-1:0]      addr;
    logic [DBUS_BE_BUS-1:0]  be;
    logic [REG_BUS-1:0]      wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [REG_BUS-1:0]      rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/ex_mem_lsu_align.sv
// Combinational lane logic: byte enables, store replication, misalign
// detection and load sign/zero extension.
module lsu_align
    import ex_mem_pkg::*;
(
    input  logic [3:0]             op,
    input  logic [1:0]             addr_lo,
    input  logic [REG_BUS-1:0]     sdata,
    input  logic [REG_BUS-1:0]     rdata,
    output logic [DBUS_BE_BUS-1:0] be,
    output logic [REG_BUS-1:0]     wdata,
    output logic                   misalign,
    output logic [REG_BUS-1:0]     ldata
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = byte_lane[addr_lo];
    assign sel_half = addr_lo[1] ? {byte_lane[3], byte_lane[2]} : {byte_lane[1], byte_lane[0]};

    always_comb begin
        be       = '0;
        wdata    = '0;
        misalign = 1'b0;
        ldata    = '0;
        case (op)
            MEM_OP_LB: begin
                be    = 4'b0001 << addr_lo;
                ldata = {{24{sel_byte[7]}}, sel_byte};
            end
            MEM_OP_LBU: begin
                be    = 4'b0001 << addr_lo;
                ldata = {24'd0, sel_byte};
            end
            MEM_OP_LH: begin
                be       = 4'b0011 << addr_lo;
                misalign = addr_lo[0];
                ldata    = {{16{sel_half[15]}}, sel_half};
            end
            MEM_OP_LHU: begin
                be       = 4'b0011 << addr_lo;
                misalign = addr_lo[0];
                ldata    = {16'd0, sel_half};
            end
            MEM_OP_LW: begin
                be       = 4'b1111;
                misalign = (addr_lo != 2'b00);
                ldata    = rdata;
            end
            MEM_OP_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEM_OP_SH: begin
                be       = 4'b0011 << addr_lo;
                wdata    = {2{sdata[15:0]}};
                misalign = addr_lo[0];
            end
            MEM_OP_SW: begin
                be       = 4'b1111;
                wdata    = sdata;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with a single-outstanding data-bus access FSM;
// stalls the pipe while a load/store is in flight.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [REG_ADDR_BUS-1:0] ex_waddr,
    input  logic [REG_BUS-1:0]      ex_wdata,
    input  logic                    ex_we,
    input  logic                    ex_csr_we,
    input  logic [CSR_ADDR_BUS-1:0] ex_csr_waddr,
    input  logic [CSR_BUS-1:0]      ex_csr_wdata,
    input  logic [3:0]              ex_mem_op,
    input  logic [REG_BUS-1:0]      ex_mem_addr,
    input  logic [REG_BUS-1:0]      ex_mem_sdata,
    input  logic                    flush,
    output logic                    stall_req,
    ex_mem_if.master                dbus,
    output logic                    exm_valid,
    output logic [REG_ADDR_BUS-1:0] exm_waddr,
    output logic [REG_BUS-1:0]      exm_wdata,
    output logic                    exm_we,
    output logic                    exm_csr_we,
    output logic [CSR_ADDR_BUS-1:0] exm_csr_waddr,
    output logic [CSR_BUS-1:0]      exm_csr_wdata,
    output logic                    exm_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e                  state_reg;
    logic [3:0]              op_reg;
    logic [1:0]              addr_lo_reg;
    logic [REG_ADDR_BUS-1:0] waddr_reg;

    logic [3:0]              op_sel;
    logic [1:0]              addr_lo_sel;
    logic [DBUS_BE_BUS-1:0]  al_be;
    logic [REG_BUS-1:0]      al_wdata;
    logic                    al_misalign;
    logic [REG_BUS-1:0]      al_ldata;

    // One aligner serves both directions: incoming op in IDLE, captured op afterwards.
    assign op_sel      = (state_reg == ST_IDLE) ? ex_mem_op : op_reg;
    assign addr_lo_sel = (state_reg == ST_IDLE) ? ex_mem_addr[1:0] : addr_lo_reg;

    lsu_align u_lsu_align (
        .op       (op_sel),
        .addr_lo  (addr_lo_sel),
        .sdata    (ex_mem_sdata),
        .rdata    (dbus.rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .misalign (al_misalign),
        .ldata    (al_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg     <= ST_IDLE;
            op_reg        <= MEM_OP_NONE;
            addr_lo_reg   <= '0;
            waddr_reg     <= '0;
            stall_req     <= 1'b0;
            dbus.req      <= 1'b0;
            dbus.we       <= 1'b0;
            dbus.addr     <= '0;
            dbus.be       <= '0;
            dbus.wdata    <= '0;
            exm_valid     <= 1'b0;
            exm_waddr     <= '0;
            exm_wdata     <= '0;
            exm_we        <= 1'b0;
            exm_csr_we    <= 1'b0;
            exm_csr_waddr <= '0;
            exm_csr_wdata <= '0;
            exm_misalign  <= 1'b0;
        end else begin
            // Every exm_* beat lasts one cycle; a bubble unless overridden below.
            exm_valid     <= 1'b0;
            exm_waddr     <= '0;
            exm_wdata     <= '0;
            exm_we        <= 1'b0;
            exm_csr_we    <= 1'b0;
            exm_csr_waddr <= '0;
            exm_csr_wdata <= '0;
            exm_misalign  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (ex_valid && !flush) begin
                        if (!op_is_mem(ex_mem_op)) begin
                            exm_valid     <= 1'b1;
                            exm_waddr     <= ex_waddr;
                            exm_wdata     <= ex_wdata;
                            exm_we        <= ex_we;
                            exm_csr_we    <= ex_csr_we;
                            exm_csr_waddr <= ex_csr_waddr;
                            exm_csr_wdata <= ex_csr_wdata;
                        end else if (al_misalign) begin
                            exm_valid    <= 1'b1;
                            exm_misalign <= 1'b1;
                            exm_waddr    <= ex_waddr;
                        end else begin
                            op_reg      <= ex_mem_op;
                            addr_lo_reg <= ex_mem_addr[1:0];
                            waddr_reg   <= ex_waddr;
                            dbus.req    <= 1'b1;
                            dbus.we     <= op_is_store(ex_mem_op);
                            dbus.addr   <= {ex_mem_addr[REG_BUS-1:2], 2'b00};
                            dbus.be     <= al_be;
                            dbus.wdata  <= al_wdata;
                            stall_req   <= 1'b1;
                            state_reg   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        dbus.req <= 1'b0;
                        // A grant in the flush cycle still owes us an rvalid.
                        if (dbus.gnt) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            stall_req <= 1'b0;
                            state_reg <= ST_IDLE;
                        end
                    end else if (dbus.gnt) begin
                        dbus.req  <= 1'b0;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dbus.rvalid) begin
                        stall_req <= 1'b0;
                        state_reg <= ST_IDLE;
                        if (!flush) begin
                            exm_valid <= 1'b1;
                            exm_waddr <= waddr_reg;
                            if (op_is_load(op_reg)) begin
                                exm_we    <= 1'b1;
                                exm_wdata <= al_ldata;
                            end
                        end
                    end else if (flush) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (dbus.rvalid) begin
                        stall_req <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    dbus.req  <= 1'b0;
                    stall_req <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed-vector bench for ex_mem: non-memory ops, loads, stores,
// misalign, flush in each state and mid-transaction reset.
module tb_ex_mem;
    import ex_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_we;
    logic        ex_csr_we;
    logic [11:0] ex_csr_waddr;
    logic [31:0] ex_csr_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_sdata;
    logic        flush;
    logic        stall_req;
    logic        exm_valid;
    logic [4:0]  exm_waddr;
    logic [31:0] exm_wdata;
    logic        exm_we;
    logic        exm_csr_we;
    logic [11:0] exm_csr_waddr;
    logic [31:0] exm_csr_wdata;
    logic        exm_misalign;

    int n_vec;
    int n_err;

    ex_mem_if dbus_if ();

    ex_mem dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_waddr      (ex_waddr),
        .ex_wdata      (ex_wdata),
        .ex_we         (ex_we),
        .ex_csr_we     (ex_csr_we),
        .ex_csr_waddr  (ex_csr_waddr),
        .ex_csr_wdata  (ex_csr_wdata),
        .ex_mem_op     (ex_mem_op),
        .ex_mem_addr   (ex_mem_addr),
        .ex_mem_sdata  (ex_mem_sdata),
        .flush         (flush),
        .stall_req     (stall_req),
        .dbus          (dbus_if),
        .exm_valid     (exm_valid),
        .exm_waddr     (exm_waddr),
        .exm_wdata     (exm_wdata),
        .exm_we        (exm_we),
        .exm_csr_we    (exm_csr_we),
        .exm_csr_waddr (exm_csr_waddr),
        .exm_csr_wdata (exm_csr_wdata),
        .exm_misalign  (exm_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] waddr);
        ex_valid     = 1'b1;
        ex_mem_op    = op;
        ex_mem_addr  = addr;
        ex_mem_sdata = sdata;
        ex_waddr     = waddr;
        ex_we        = 1'b1;
        ex_wdata     = 32'h5555_5555;
        tick();
        ex_valid  = 1'b0;
        ex_mem_op = MEM_OP_NONE;
    endtask

    task automatic run_load(input string name, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] exp_addr, input logic [31:0] rdata,
                            input logic [31:0] exp);
        issue(op, addr, 32'h0, 5'd9);
        chk({name, "_req"}, dbus_if.req, 1);
        chk({name, "_we"}, dbus_if.we, 0);
        chk({name, "_addr"}, dbus_if.addr, exp_addr);
        chk({name, "_stall1"}, stall_req, 1);
        dbus_if.gnt = 1'b1;
        tick();
        dbus_if.gnt = 1'b0;
        chk({name, "_reqdrop"}, dbus_if.req, 0);
        chk({name, "_stall2"}, stall_req, 1);
        chk({name, "_novalid"}, exm_valid, 0);
        dbus_if.rvalid = 1'b1;
        dbus_if.rdata  = rdata;
        tick();
        dbus_if.rvalid = 1'b0;
        chk({name, "_valid"}, exm_valid, 1);
        chk({name, "_exmwe"}, exm_we, 1);
        chk({name, "_waddr"}, exm_waddr, 9);
        chk({name, "_data"}, exm_wdata, exp);
        chk({name, "_stall3"}, stall_req, 0);
        $display("txn %s addr=0x%08h rdata=0x%08h -> wdata=0x%08h", name, addr, rdata, exm_wdata);
        tick();
        chk({name, "_oneshot"}, exm_valid, 0);
    endtask

    task automatic run_store(input string name, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input int gnt_delay);
        issue(op, addr, sdata, 5'd3);
        for (int i = 0; i < gnt_delay; i++) begin
            chk({name, "_hold_req"}, dbus_if.req, 1);
            chk({name, "_hold_be"}, dbus_if.be, exp_be);
            chk({name, "_hold_wdata"}, dbus_if.wdata, exp_wdata);
            tick();
        end
        chk({name, "_req"}, dbus_if.req, 1);
        chk({name, "_we"}, dbus_if.we, 1);
        chk({name, "_addr"}, dbus_if.addr, exp_addr);
        chk({name, "_be"}, dbus_if.be, exp_be);
        chk({name, "_wdata"}, dbus_if.wdata, exp_wdata);
        dbus_if.gnt = 1'b1;
        tick();
        dbus_if.gnt = 1'b0;
        chk({name, "_reqdrop"}, dbus_if.req, 0);
        dbus_if.rvalid = 1'b1;
        tick();
        dbus_if.rvalid = 1'b0;
        chk({name, "_valid"}, exm_valid, 1);
        chk({name, "_exmwe"}, exm_we, 0);
        chk({name, "_stall"}, stall_req, 0);
        $display("txn %s addr=0x%08h be=%b wdata=0x%08h", name, addr, exp_be, exp_wdata);
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        ex_valid = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_we = 1'b0;
        ex_csr_we = 1'b0; ex_csr_waddr = '0; ex_csr_wdata = '0;
        ex_mem_op = MEM_OP_NONE; ex_mem_addr = '0; ex_mem_sdata = '0; flush = 1'b0;
        dbus_if.gnt = 1'b0; dbus_if.rvalid = 1'b0; dbus_if.rdata = '0;
        tick();
        tick();
        chk("rst_stall", stall_req, 0);
        chk("rst_req", dbus_if.req, 0);
        chk("rst_valid", exm_valid, 0);
        chk("rst_wdata", exm_wdata, 0);
        $display("txn reset");
        rst = 1'b1;
        tick();

        // Non-memory op with GPR and CSR writes
        ex_valid = 1'b1; ex_mem_op = MEM_OP_NONE; ex_we = 1'b1; ex_waddr = 5'd5;
        ex_wdata = 32'h1234; ex_csr_we = 1'b1; ex_csr_waddr = 12'h300; ex_csr_wdata = 32'hDEAD_BEEF;
        tick();
        ex_valid = 1'b0; ex_csr_we = 1'b0;
        chk("alu_valid", exm_valid, 1);
        chk("alu_we", exm_we, 1);
        chk("alu_waddr", exm_waddr, 5);
        chk("alu_wdata", exm_wdata, 32'h1234);
        chk("alu_csr_we", exm_csr_we, 1);
        chk("alu_csr_waddr", exm_csr_waddr, 32'h300);
        chk("alu_csr_wdata", exm_csr_wdata, 32'hDEAD_BEEF);
        chk("alu_stall", stall_req, 0);
        $display("txn alu waddr=5 wdata=0x%08h", exm_wdata);
        tick();
        chk("bubble_valid", exm_valid, 0);
        chk("bubble_wdata", exm_wdata, 0);
        chk("bubble_csr_we", exm_csr_we, 0);

        run_load("lb",  MEM_OP_LB,  32'h103, 32'h100, 32'h80FF_FFFF, 32'hFFFF_FF80);
        run_load("lbu", MEM_OP_LBU, 32'h103, 32'h100, 32'h80FF_FFFF, 32'h0000_0080);
        run_load("lb1", MEM_OP_LB,  32'h101, 32'h100, 32'h0000_7F00, 32'h0000_007F);
        run_load("lh",  MEM_OP_LH,  32'h102, 32'h100, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lhu", MEM_OP_LHU, 32'h100, 32'h100, 32'h1234_8765, 32'h0000_8765);
        run_load("lw",  MEM_OP_LW,  32'h104, 32'h104, 32'hCAFE_BABE, 32'hCAFE_BABE);

        run_store("sh", MEM_OP_SH, 32'h202, 32'h0000_ABCD, 32'h200, 4'b1100, 32'hABCD_ABCD, 3);
        run_store("sb", MEM_OP_SB, 32'h003, 32'h1234_5678, 32'h000, 4'b1000, 32'h7878_7878, 0);
        run_store("sw", MEM_OP_SW, 32'h008, 32'h0BAD_F00D, 32'h008, 4'b1111, 32'h0BAD_F00D, 1);

        // Misaligned word and halfword
        issue(MEM_OP_LW, 32'h101, 32'h0, 5'd12);
        chk("mis_lw_flag", exm_misalign, 1);
        chk("mis_lw_valid", exm_valid, 1);
        chk("mis_lw_we", exm_we, 0);
        chk("mis_lw_waddr", exm_waddr, 12);
        chk("mis_lw_req", dbus_if.req, 0);
        chk("mis_lw_stall", stall_req, 0);
        $display("txn misaligned lw addr=0x101");
        issue(MEM_OP_SH, 32'h203, 32'h0, 5'd0);
        chk("mis_sh_flag", exm_misalign, 1);
        chk("mis_sh_req", dbus_if.req, 0);
        $display("txn misaligned sh addr=0x203");
        tick();
        chk("mis_clear", exm_misalign, 0);

        // Flush in WAIT: drain the late rvalid
        issue(MEM_OP_LW, 32'h100, 32'h0, 5'd4);
        dbus_if.gnt = 1'b1;
        tick();
        dbus_if.gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fw_stall_a", stall_req, 1);
        chk("fw_valid_a", exm_valid, 0);
        tick();
        chk("fw_stall_b", stall_req, 1);
        dbus_if.rvalid = 1'b1; dbus_if.rdata = 32'h1111_1111;
        tick();
        dbus_if.rvalid = 1'b0;
        chk("fw_stall_c", stall_req, 0);
        chk("fw_valid_c", exm_valid, 0);
        chk("fw_we_c", exm_we, 0);
        $display("txn flush-in-wait drained");

        // Flush in REQ before grant
        issue(MEM_OP_LW, 32'h100, 32'h0, 5'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fr_req", dbus_if.req, 0);
        chk("fr_stall", stall_req, 0);
        chk("fr_valid", exm_valid, 0);
        $display("txn flush-in-req");

        // Flush in REQ coincident with grant
        issue(MEM_OP_LW, 32'h100, 32'h0, 5'd4);
        flush = 1'b1; dbus_if.gnt = 1'b1;
        tick();
        flush = 1'b0; dbus_if.gnt = 1'b0;
        chk("fg_req", dbus_if.req, 0);
        chk("fg_stall", stall_req, 1);
        dbus_if.rvalid = 1'b1;
        tick();
        dbus_if.rvalid = 1'b0;
        chk("fg_stall_end", stall_req, 0);
        chk("fg_valid", exm_valid, 0);
        $display("txn flush-with-gnt drained");

        // Flush in IDLE
        ex_valid = 1'b1; ex_mem_op = MEM_OP_NONE; ex_we = 1'b1; ex_waddr = 5'd6; flush = 1'b1;
        tick();
        ex_valid = 1'b0; flush = 1'b0;
        chk("fi_valid", exm_valid, 0);
        chk("fi_we", exm_we, 0);
        $display("txn flush-in-idle");

        // Reset mid-REQ
        issue(MEM_OP_SW, 32'h40, 32'hFFFF_FFFF, 5'd2);
        chk("rr_req_before", dbus_if.req, 1);
        rst = 1'b0;
        tick();
        chk("rr_req", dbus_if.req, 0);
        chk("rr_we", dbus_if.we, 0);
        chk("rr_addr", dbus_if.addr, 0);
        chk("rr_be", dbus_if.be, 0);
        chk("rr_wdata", dbus_if.wdata, 0);
        chk("rr_stall", stall_req, 0);
        chk("rr_valid", exm_valid, 0);
        rst = 1'b1;
        ex_valid = 1'b1; ex_mem_op = MEM_OP_NONE; ex_we = 1'b1; ex_waddr = 5'd8; ex_wdata = 32'h77;
        tick();
        ex_valid = 1'b0;
        chk("rr_idle_valid", exm_valid, 1);
        chk("rr_idle_wdata", exm_wdata, 32'h77);
        $display("txn reset-mid-req");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register and data-memory access controller between the execute stage and the combinational `mem` stage. It registers ALU and CSR results from `ex` and presents them as `exm_*` to `mem`. For loads and stores it runs a req/gnt/rvalid transaction on the data bus, stalls the pipeline until the access completes, and returns aligned, extended load data as the register write value.

## Interface
Parameters:
- none; widths come from `defines.v`: `RegBus`=32, `RegAddrBus`=5, `CsrAddrBus`=12, `CsrBus`=32.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-low.
- `ex_valid` in 1: an instruction is present on `ex_*`.
- `ex_waddr` in 5, `ex_wdata` in 32, `ex_we` in 1: GPR write from `ex`.
- `ex_csr_we` in 1, `ex_csr_waddr` in 12, `ex_csr_wdata` in 32: CSR write from `ex`.
- `ex_mem_op` in 4: MemOpNone/LB/LH/LW/LBU/LHU/SB/SH/SW.
- `ex_mem_addr` in 32: effective address.
- `ex_mem_sdata` in 32: store data.
- `flush` in 1: kill the in-flight instruction.
- `stall_req` out 1: to pipeline control; upstream holds `ex_*` while it is high.
- `dbus_req` out 1, `dbus_we` out 1, `dbus_addr` out 32, `dbus_be` out 4, `dbus_wdata` out 32: bus request.
- `dbus_gnt` in 1, `dbus_rvalid` in 1, `dbus_rdata` in 32: bus response.
- `exm_valid` out 1, `exm_waddr` out 5, `exm_wdata` out 32, `exm_we` out 1: GPR write to `mem`.
- `exm_csr_we` out 1, `exm_csr_waddr` out 12, `exm_csr_wdata` out 32: CSR write to `mem`.
- `exm_misalign` out 1: misaligned-access exception flag.

## Operation
- All outputs are registered.
- A bubble means `exm_valid`=`exm_we`=`exm_csr_we`=`exm_misalign`=0; the other `exm_*` fields hold 0.
- States: IDLE, REQ, WAIT, DRAIN. `stall_req` = (state != IDLE).
- IDLE, with `ex_valid`=1 and `flush`=0:
  - Op None: copy `ex_*` to `exm_*`, `exm_valid`=1, stay in IDLE.
  - Misaligned (halfword at addr[0]=1, word at addr[1:0]≠0): `exm_valid`=1, `exm_misalign`=1, `exm_we`=0, `exm_waddr`=`ex_waddr`, `exm_csr_we`=0, no bus traffic, stay in IDLE.
  - Aligned load/store: capture op, addr, `waddr`, `dbus_*` fields, set `dbus_req`=1, output a bubble, go to REQ.
- IDLE with `ex_valid`=0: output a bubble.
- REQ: hold `dbus_req` and all `dbus_*` fields stable until `dbus_gnt`. On gnt, drop `dbus_req` and go to WAIT.
- WAIT: on `dbus_rvalid`, go to IDLE and output one valid beat:
  - load: `exm_we`=1, `exm_wdata`=extended data;
  - store: `exm_we`=0.
- `dbus_rvalid` arrives at the earliest one cycle after gnt. At most one transaction is outstanding.
- Flush:
  - IDLE: the next output is a bubble.
  - REQ before gnt: drop the request, go to IDLE.
  - REQ with gnt in the same cycle: go to DRAIN.
  - WAIT: go to DRAIN.
  - DRAIN: wait for `dbus_rvalid`, discard it, go to IDLE. Outputs are bubbles throughout.
- Store lanes, with a = addr[1:0]:
  - SB: be=0001<<a, wdata={4{sdata[7:0]}}.
  - SH: be=0011<<a, wdata={2{sdata[15:0]}}.
  - SW: be=1111, wdata=sdata.
  - `dbus_addr` = {addr[31:2],2'b00}.
- Load extraction: byte = rdata[8a+7:8a], half = rdata[16a+15:16a] (a = addr[1] for halves). LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.

## Timing
- Reset: on a `clk` edge with `rst`=0, state=IDLE, every output is 0 (including `dbus_req` and `stall_req`), with no exceptions. A reset mid-transaction abandons the transaction without draining. The bus is reset together with this block.
- Non-memory op: sampled at edge N, `exm_*` valid after edge N, for one cycle.
- Load/store with zero-wait gnt and next-cycle rvalid:
  - edge 0: capture;
  - cycle 1: req+gnt;
  - cycle 2: rvalid;
  - result valid in cycle 3.
- `stall_req` is high in cycles 1–2.
- `stall_req` falls on the same edge that registers the result, so the next instruction is accepted on the following edge.
- `ex_*` are ignored while `stall_req`=1.

## Structure
- `defines.v` gains the MemOp encodings (MemOpNone=4'h0 … MemOpSW), `DBusBeBus`, and `RstEnable`=1'b0. State encodings are local parameters.
- One combinational sub-module, `lsu_align`, computes `be`, store replication, the misalign check, and load extension. It is unit-testable on its own.

## Test plan
- Non-memory op, `ex_we`=1, waddr=5, wdata=0x1234 → `exm_valid`=1, `exm_we`=1, waddr=5, wdata=0x1234 one cycle later; `stall_req` stays 0.
- LB at addr 0x103, rdata=0x80FFFFFF, gnt immediate, rvalid next cycle → `dbus_addr`=0x100, `exm_wdata`=0xFFFFFF80 valid 3 cycles after capture. LBU under the same stimulus → 0x00000080.
- SH at 0x202, sdata=0xABCD, gnt delayed 3 cycles → req and fields stable for 4 cycles, be=1100, wdata=0xABCDABCD; `exm_we`=0 on rvalid.
- LW at 0x101 → `exm_misalign`=1, `dbus_req` never asserted, `stall_req`=0.
- LW granted, `flush` in WAIT, rvalid 2 cycles later → DRAIN, no valid output, `stall_req` held until rvalid. Flush in REQ before gnt → req drops next cycle, IDLE.
- `rst`=0 asserted mid-REQ → next cycle all outputs 0, state IDLE.
